// File: rtl/npc_fetch_unit.sv
// npc_fetch_unit: sequential instruction-fetch front end of the single-cycle RISC-V core.
//
// Owns the PC. It fetches one instruction over a req/ack handshake and holds it
// until the core commits. It then computes the next PC from the control unit's
// select and starts the next fetch.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the retire_cnt_o and
// stall_cnt_o performance counters.
//
// Ports:
//   clk_i          core clock
//   rst_ni         synchronous active-low reset
//   npc_op_i       next-PC select: 00 PC+4, 01 (rs1+imm)&~1, 10 PC+imm, 11 PC+4
//   rs1_i, imm_i   JALR base register and sign-extended immediate
//   commit_i       current instruction finished (honoured only while inst_valid_o=1)
//   imem_req_o     fetch request; imem_addr_o is the fetch address (= pc_o)
//   imem_ack_i     imem_rdata_i holds the fetched word this cycle
//   pc_o, pc4_o    address of the held instruction and that address plus 4
//   inst_o         held instruction word; inst_valid_o marks it executable
//   misalign_o     sticky: fetch halted on a misaligned target
//   retire_cnt_o   accepted commits (FETCH_PERF_CNT_EN only)
//   stall_cnt_o    request cycles without ack (FETCH_PERF_CNT_EN only)
module npc_fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [1:0]      npc_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            commit_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     retire_cnt_o,
    output logic [31:0]     stall_cnt_o,
`endif
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {StBoot, StReq, StExec, StHalt} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] target;
    logic            commit_accept;

    assign pc4 = pc_q + XLEN'(4);
    // commit is only meaningful while an instruction is held (StExec).
    assign commit_accept = (state_q == StExec) && commit_i;

    always_comb begin
        target = pc4;
        case (npc_op_i)
            2'b01:   target = (rs1_i + imm_i) & ~XLEN'(1);
            2'b10:   target = pc_q + imm_i;
            default: target = pc4;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        unique case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (imem_ack_i) begin
                    inst_d       = imem_rdata_i;
                    inst_valid_d = 1'b1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (commit_accept) begin
                    inst_valid_d = 1'b0;
                    if (target[1:0] == 2'b00) begin
                        pc_d    = target;
                        state_d = StReq;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end
                end
            end
            StHalt: inst_valid_d = 1'b0;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            inst_q       <= Nop;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req_o   = (state_q == StReq);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign pc4_o        = pc4;
    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign misalign_o   = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (commit_accept) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
            end
            if ((state_q == StReq) && !imem_ack_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign retire_cnt_o = retire_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Directed bench for npc_fetch_unit: expected fetch addresses are queued when a
// commit or reset is driven and popped when the memory model serves the fetch.
module tb_npc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  npc_op;
    logic [31:0] rs1, imm;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, pc4, inst;
    logic        inst_valid, misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retire_cnt, stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    int          m_retire, m_stall;

    always #5 clk = ~clk;

    npc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .npc_op_i    (npc_op),
        .rs1_i       (rs1),
        .imm_i       (imm),
        .commit_i    (commit),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_rdata_i(imem_rdata),
        .pc_o        (pc),
        .pc4_o       (pc4),
        .inst_o      (inst),
        .inst_valid_o(inst_valid),
`ifdef FETCH_PERF_CNT_EN
        .retire_cnt_o(retire_cnt),
        .stall_cnt_o (stall_cnt),
`endif
        .misalign_o  (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h4);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_misalign", {31'b0, misalign}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_retire", retire_cnt, 32'h0);
        check("rst_stall", stall_cnt, 32'h0);
`endif
    endtask

    // Called at a negedge; serves one fetch, acking on the delay-th request cycle.
    task automatic fetch(input int delay, input logic [31:0] data);
        logic [31:0] exp_addr;
        int waited = 0;
        while (!imem_req && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("req_wait", {31'b0, imem_req}, 32'h1);
        exp_addr = exp_q.pop_front();
        for (int i = 1; i <= delay; i++) begin
            check("req_held", {31'b0, imem_req}, 32'h1);
            check("fetch_addr", imem_addr, exp_addr);
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? data : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        m_stall += delay - 1;
        check("exec_valid", {31'b0, inst_valid}, 32'h1);
        check("exec_inst", inst, data);
        check("exec_req", {31'b0, imem_req}, 32'h0);
        check("exec_pc", pc, exp_addr);
        check("exec_pc4", pc4, exp_addr + 32'd4);
        m_pc = exp_addr;
    endtask

    // Called at a negedge in execute; commits and checks the resulting state.
    task automatic do_commit(input logic [1:0] op, input logic [31:0] r, input logic [31:0] i);
        logic [31:0] tgt;
        case (op)
            2'b01:   tgt = (r + i) & 32'hFFFF_FFFE;
            2'b10:   tgt = m_pc + i;
            default: tgt = m_pc + 32'd4;
        endcase
        npc_op = op;
        rs1    = r;
        imm    = i;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        m_retire++;
        check("cmt_valid", {31'b0, inst_valid}, 32'h0);
        if (tgt[1:0] == 2'b00) begin
            m_pc = tgt;
            exp_q.push_back(tgt);
            check("cmt_req", {31'b0, imem_req}, 32'h1);
            check("cmt_pc", pc, tgt);
        end else begin
            check("halt_misalign", {31'b0, misalign}, 32'h1);
            check("halt_req", {31'b0, imem_req}, 32'h0);
            check("halt_pc", pc, m_pc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        commit = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state();
        m_retire = 0;
        m_stall  = 0;
        rst_n = 1'b1;
        m_pc = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        npc_op = 2'b00;
        rs1 = '0;
        imm = '0;
        commit = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        m_retire = 0;
        m_stall = 0;

        // Zero-wait memory, sequential PC+4 flow.
        do_reset();
        fetch(1, 32'h0040_0093);
        do_commit(2'b00, 32'h0, 32'h0);
        fetch(3, 32'h0010_8113);
`ifdef FETCH_PERF_CNT_EN
        check("stall_3cyc", stall_cnt, 32'd2);
`endif
        check("pc4_at_4", pc4, 32'h8);
        do_commit(2'b00, 32'h0, 32'h0);
        fetch(1, 32'h0000_0013);
        do_commit(2'b00, 32'h0, 32'h0);
        fetch(2, 32'h0000_0013);
        do_commit(2'b00, 32'h0, 32'h0);
        fetch(1, 32'h0000_0013);

        // Branch and JALR targets from pc=0x10.
        check("pc_is_10", pc, 32'h10);
        do_commit(2'b10, 32'h0, 32'hFFFF_FFF8);
        fetch(1, 32'h1234_5678);
        do_commit(2'b01, 32'h101, 32'h3);
        fetch(2, 32'h8765_4321);

        // PC wrap at the top of the address space.
        do_commit(2'b10, 32'h0, 32'hFFFF_FEF8);
        fetch(1, 32'h0000_0013);
        check("pc4_wrap", pc4, 32'h0);
        do_commit(2'b11, 32'h0, 32'h0);

        // Commit while no instruction is held must be ignored.
        npc_op = 2'b10;
        imm = 32'h100;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        m_stall++;
        check("ign_cmt_pc", pc, 32'h0);
        check("ign_cmt_req", {31'b0, imem_req}, 32'h1);
        fetch(1, 32'h0000_0013);

        // Reset in the middle of a pending fetch, then a stray ack during boot.
        do_commit(2'b00, 32'h0, 32'h0);
        check("abort_addr", imem_addr, exp_q.pop_front());
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_reset_state();
        m_retire = 0;
        m_stall = 0;
        m_pc = 32'h0;
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("boot_req", {31'b0, imem_req}, 32'h1);
        check("boot_valid", {31'b0, inst_valid}, 32'h0);
        check("boot_inst", inst, 32'h0000_0013);
        exp_q.push_back(32'h0);
        fetch(1, 32'h0000_0013);

        // Misaligned JALR halts; later commits change nothing.
        do_commit(2'b01, 32'h2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            commit = (k % 2 == 0);
            npc_op = 2'b00;
            @(negedge clk);
            check("halt_hold_req", {31'b0, imem_req}, 32'h0);
            check("halt_hold_mis", {31'b0, misalign}, 32'h1);
            check("halt_hold_pc", pc, m_pc);
            check("halt_hold_val", {31'b0, inst_valid}, 32'h0);
        end
        commit = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check("retire_cnt", retire_cnt, 32'(m_retire));
        check("stall_cnt", stall_cnt, 32'(m_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_fetch_unit.md
Name: npc_fetch_unit

Overview:
- Sequential front end of the single-cycle RISC-V core; consumes the control unit's 2-bit next-PC select (PC+4 / rs1+imm / PC+imm).
- Owns the PC register and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the held instruction word, so the decoder sees opcode/funct3/funct7, until the core pulses commit.
- On commit, computes and loads the next PC and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width; fixed at 32 for this core.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- npc_op  in  2  next-PC select: 00 PC+4, 01 (rs1+imm)&~1, 10 PC+imm, 11 treated as PC+4.
- rs1  in  32  register-file operand used for JALR target.
- imm  in  32  sign-extended immediate.
- commit  in  1  core finished executing the current instruction; valid only while inst_valid=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc  out  32  address of the held instruction.
- pc4  out  32  pc+4, used for the JAL/JALR writeback.
- inst  out  32  held instruction word.
- inst_valid  out  1  inst is valid for execution.
- misalign  out  1  sticky flag: fetch halted on a misaligned target.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Reset values: pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, imem_req=0, misalign=0, state=S_BOOT.
  - Reset overrides every other input and aborts any outstanding fetch; a late imem_ack after reset is ignored until S_REQ.
- State machine S_BOOT, S_REQ, S_EXEC, S_HALT:
  - S_BOOT: one idle cycle after reset release, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc.
    - If imem_ack=1 in a cycle with imem_req=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, go to S_EXEC. Ack on the first request cycle is legal, giving minimum fetch latency of 1 cycle after req rises.
    - Otherwise hold req and addr stable. There is no timeout.
  - S_EXEC: inst, pc and pc4 are stable; imem_req=0; imem_ack is ignored.
    - On commit=1, compute target:
      - 00 or 11: pc+4.
      - 01: (rs1+imm) with bit0 cleared.
      - 10: pc+imm.
      - All additions are modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.
    - If target[1:0]==0: pc<=target, inst_valid<=0, go to S_REQ. The next req rises in the cycle after commit.
    - Else: misalign<=1, inst_valid<=0, pc unchanged, go to S_HALT.
  - S_HALT: imem_req=0, inst_valid=0; exit only by reset.
- commit when inst_valid=0 is ignored.
- pc4 is combinational pc+4 at all times.
- Throughput: one instruction per (fetch latency + commit wait + 1) cycles.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs retire_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - retire_cnt increments on each accepted commit, including one that halts.
  - stall_cnt increments every S_REQ cycle with imem_ack=0.
  - Both wrap at 2^32.
- When undefined, both ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset then zero-wait memory (ack in the same cycle as req) -> first imem_addr=0x0, inst_valid rises next cycle; commit with npc_op=00 -> next imem_addr=0x4, pc4=0x8.
- Memory with 3-cycle ack delay -> imem_req/imem_addr held for 3 cycles, inst=imem_rdata on ack; stall_cnt=2 per fetch if FETCH_PERF_CNT_EN.
- pc=0x10, npc_op=10, imm=0xFFFF_FFF8 -> next fetch 0x08; npc_op=01, rs1=0x101, imm=0x3 -> 0x104.
- npc_op=01, rs1=0x2, imm=0 -> target 0x2 -> misalign=1, S_HALT, no further imem_req despite repeated commit.
- rst_n=0 asserted mid-S_REQ while ack pending -> next cycle pc=RESET_PC, imem_req=0, inst_valid=0, misalign=0; stray ack during S_BOOT is ignored.
- pc=0xFFFF_FFFC, npc_op=00 commit -> pc wraps to 0x0; commit pulsed with inst_valid=0 -> no PC change.
